regfile_np: RTL and testbench

Parametrised multi-port register file for the LEGv8 datapath, generalising the fixed 32:1 bit-select mux into a full storage array. It holds DEPTH registers of WIDTH bits, has one synchronous write port and N_RD independent combinational read ports, each built from a parametrised N:1 mux tree. Optional features are a hardwired-zero top register (XZR) and write-to-read bypass. It sits between decode and execute and replaces the hand-built 32x64 regfile.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_np_mux.sv | 56 +++++
 rtl/regfile_np.sv | 87 ++++++++
 tb/tb_regfile_np.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 register file.
// Defaults describe the 32 x 64-bit LEGv8 file with X31 acting as XZR.
package regfile_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int DEPTH_DEF = 32;
    localparam int XZR_IDX   = DEPTH_DEF - 1;

    typedef logic [$clog2(DEPTH_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_np_mux.sv
// Bit-level multiplexers for the register file read path.
// An N:1 mux is two N/2:1 halves joined by a final 2:1 stage that is steered by the select MSB.
module mux2_1 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

module mux_n_1 #(
    parameter  int N  = 2,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  data_i,
    input  logic [SW-1:0] sel_i,
    output logic          y_o
);

    generate
        if (N == 2) begin : g_leaf
            mux2_1 u_mux (
                .a_i  (data_i[0]),
                .b_i  (data_i[1]),
                .sel_i(sel_i[0]),
                .y_o  (y_o)
            );
        end else begin : g_node
            logic lo;
            logic hi;

            mux_n_1 #(.N(N/2)) u_lo (
                .data_i(data_i[N/2-1:0]),
                .sel_i (sel_i[SW-2:0]),
                .y_o   (lo)
            );

            mux_n_1 #(.N(N/2)) u_hi (
                .data_i(data_i[N-1:N/2]),
                .sel_i (sel_i[SW-2:0]),
                .y_o   (hi)
            );

            mux2_1 u_mux (
                .a_i  (lo),
                .b_i  (hi),
                .sel_i(sel_i[SW-1]),
                .y_o  (y_o)
            );
        end
    endgenerate

endmodule

// File: rtl/regfile_np.sv
// Multi-port register file: one synchronous write port and N_RD combinational read ports.
// Optional features are a hardwired-zero top register and write-to-read forwarding.
module regfile_np
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = WIDTH_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int N_RD     = 2,
    parameter  bit ZERO_REG = 1'b1,
    parameter  bit BYPASS   = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [N_RD*AW-1:0]     rd_addr,
    output logic [N_RD*WIDTH-1:0]  rd_data
);

    localparam logic [AW-1:0] TOP_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] load_en;
    logic [DEPTH-1:0] col [WIDTH];

    // NOTE: load_en is cleared before the decode so every path assigns it and no latch is inferred.
    always_comb begin
        load_en = '0;
        if (wr_en && !(ZERO_REG && (wr_addr == TOP_IDX))) begin
            load_en[wr_addr] = 1'b1;
        end
    end

    // NOTE: the array is reset explicitly because reset is its only initialisation path;
    // reset also wins over a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (load_en[r]) begin
                    mem_q[r] <= wr_data;
                end
            end
        end
    end

    // Transpose the array so that each mux reads one bit column across every register.
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            for (int r = 0; r < DEPTH; r++) begin
                col[b][r] = mem_q[r][b];
            end
        end
    end

    generate
        for (genvar p = 0; p < N_RD; p++) begin : g_port
            logic [AW-1:0]    addr;
            logic [WIDTH-1:0] stored;
            logic             zero_hit;
            logic             byp_hit;

            assign addr = rd_addr[p*AW +: AW];

            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                mux_n_1 #(.N(DEPTH)) u_mux (
                    .data_i(col[b]),
                    .sel_i (addr),
                    .y_o   (stored[b])
                );
            end

            // The zero register wins over forwarding; a reset cycle never forwards.
            assign zero_hit = ZERO_REG && (addr == TOP_IDX);
            assign byp_hit  = BYPASS && wr_en && !reset && (addr == wr_addr);

            assign rd_data[p*WIDTH +: WIDTH] = zero_hit ? '0 :
                                               byp_hit  ? wr_data : stored;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_np.sv
// Scoreboard bench for regfile_np: a 64x32 XZR/bypass instance and a 16x8 three-port plain instance.
// The driver pushes reference-model expectations and a negedge monitor pops and compares them.
module tb_regfile_np;
    import regfile_pkg::*;

    localparam int WB  = 16;
    localparam int DB  = 8;
    localparam int AWB = 3;
    localparam int NB  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (ZERO_REG=1, BYPASS=1, two ports)
    logic                   a_rst, a_we;
    reg_idx_t               a_wa;
    logic [WIDTH_DEF-1:0]   a_wd;
    reg_idx_t               a_ra [2];
    logic [2*5-1:0]         rd_addr_a;
    logic [2*WIDTH_DEF-1:0] rd_data_a;
    assign rd_addr_a = {a_ra[1], a_ra[0]};

    // Instance B: ZERO_REG=0, BYPASS=0, three ports
    logic                  b_rst, b_we;
    logic [AWB-1:0]        b_wa;
    logic [WB-1:0]         b_wd;
    logic [AWB-1:0]        b_ra [NB];
    logic [NB*AWB-1:0]     rd_addr_b;
    logic [NB*WB-1:0]      rd_data_b;
    assign rd_addr_b = {b_ra[2], b_ra[1], b_ra[0]};

    regfile_np #(
        .WIDTH(WIDTH_DEF), .DEPTH(DEPTH_DEF), .N_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clk(clk), .reset(a_rst), .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    regfile_np #(
        .WIDTH(WB), .DEPTH(DB), .N_RD(NB), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .clk(clk), .reset(b_rst), .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    // Reference state: plain arrays of register contents
    logic [WIDTH_DEF-1:0] mdl_a [DEPTH_DEF];
    logic [WB-1:0]        mdl_b [DB];

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    // Read rule taken directly from the behaviour of a register file read port.
    function automatic logic [63:0] ref_read(bit zero, bit bypass, int top, int addr, bit we,
                                             bit rst, int wa, logic [63:0] wd, logic [63:0] stored);
        if (zero && addr == top) return 64'h0;
        if (bypass && we && !rst && addr == wa) return wd;
        return stored;
    endfunction

    function automatic logic [63:0] actual(int d, int p);
        if (d == 0) return rd_data_a[p*64 +: 64];
        return {48'h0, rd_data_b[p*WB +: WB]};
    endfunction

    task automatic set_a(bit rst, bit we, int wa, logic [63:0] wd, int r0, int r1);
        a_rst = rst; a_we = we; a_wa = reg_idx_t'(wa); a_wd = wd;
        a_ra[0] = reg_idx_t'(r0); a_ra[1] = reg_idx_t'(r1);
    endtask

    task automatic set_b(bit rst, bit we, int wa, logic [WB-1:0] wd, int r0, int r1, int r2);
        b_rst = rst; b_we = we; b_wa = AWB'(wa); b_wd = wd;
        b_ra[0] = AWB'(r0); b_ra[1] = AWB'(r1); b_ra[2] = AWB'(r2);
    endtask

    // Queue expectations for the current cycle, then advance the model across the edge.
    task automatic step(string tag, bit chk);
        exp_t e;
        if (chk) begin
            for (int p = 0; p < 2; p++) begin
                e.tag = tag; e.dut = 0; e.port = p;
                e.exp = ref_read(1'b1, 1'b1, DEPTH_DEF-1, int'(a_ra[p]), a_we, a_rst,
                                 int'(a_wa), a_wd, mdl_a[a_ra[p]]);
                sb.push_back(e);
            end
            for (int p = 0; p < NB; p++) begin
                e.tag = tag; e.dut = 1; e.port = p;
                e.exp = ref_read(1'b0, 1'b0, DB-1, int'(b_ra[p]), b_we, b_rst,
                                 int'(b_wa), {48'h0, b_wd}, {48'h0, mdl_b[b_ra[p]]});
                sb.push_back(e);
            end
        end
        @(posedge clk);
        if (a_rst) mdl_a = '{default: '0};
        else if (a_we && int'(a_wa) != DEPTH_DEF-1) mdl_a[a_wa] = a_wd;
        if (b_rst) mdl_b = '{default: '0};
        else if (b_we) mdl_b[b_wa] = b_wd;
        #1;
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result at the negedge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("%s %s.p%0d", e.tag, (e.dut == 0) ? "a" : "b", e.port),
                      actual(e.dut, e.port), e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        set_a(1, 0, 0, '0, 0, 0); set_b(1, 0, 0, '0, 0, 0, 0);
        step("reset", 1'b0);

        for (int i = 0; i < 32; i++) begin
            set_a(0, 0, 0, '0, i, 31 - i); set_b(0, 0, 0, '0, i % 8, (i + 3) % 8, (i + 5) % 8);
            step("reset_rd", 1'b1);
        end

        set_a(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 4, 6); set_b(0, 1, 5, 16'hBEEF, 5, 4, 6);
        step("wr_x5", 1'b1);
        set_a(0, 0, 0, '0, 5, 5); set_b(0, 0, 0, '0, 5, 5, 5);
        step("rd_x5", 1'b1);
        set_a(0, 0, 0, '0, 4, 6); set_b(0, 0, 0, '0, 4, 6, 5);
        step("rd_x4_x6", 1'b1);

        set_a(0, 1, 31, '1, 31, 31); set_b(0, 1, 7, 16'hFFFF, 7, 7, 0);
        step("wr_top", 1'b1);
        set_a(0, 0, 0, '0, 31, 30); set_b(0, 0, 0, '0, 7, 6, 7);
        step("rd_top", 1'b1);

        set_a(0, 1, 7, 64'h1234, 7, 7); set_b(0, 1, 2, 16'h1234, 2, 2, 2);
        step("same_cycle", 1'b1);
        set_a(0, 0, 0, '0, 7, 7); set_b(0, 0, 0, '0, 2, 2, 2);
        step("after_same", 1'b1);

        set_a(0, 1, 3, 64'h55, 3, 3); set_b(0, 1, 3, 16'h55, 3, 3, 3);
        step("pre_rst", 1'b1);
        set_a(1, 1, 3, 64'hAA, 3, 5); set_b(1, 1, 3, 16'hAA, 3, 5, 7);
        step("rst_wr", 1'b1);
        set_a(0, 0, 0, '0, 3, 5); set_b(0, 0, 0, '0, 3, 5, 7);
        step("post_rst", 1'b1);

        set_a(0, 1, 9, 64'h11, 9, 9); set_b(0, 1, 4, 16'h11, 4, 4, 4);
        step("b2b_1", 1'b1);
        set_a(0, 1, 9, 64'h22, 9, 9); set_b(0, 1, 4, 16'h22, 4, 4, 4);
        step("b2b_2", 1'b1);
        set_a(0, 0, 0, '0, 9, 9); set_b(0, 0, 0, '0, 4, 4, 4);
        step("b2b_rd", 1'b1);

        for (int k = 0; k < 31; k++) begin
            set_a(0, 1, k, 64'd1 << k, k, 30 - k);
            set_b(0, 1, k % 8, 16'd1 << (k % 16), k % 8, 7 - (k % 8), (k + 1) % 8);
            step("sweep_wr", 1'b1);
        end
        for (int k = 0; k < 31; k++) begin
            set_a(0, 0, 0, '0, k, 30 - k);
            set_b(0, 0, 0, '0, k % 8, 7 - (k % 8), (k + 2) % 8);
            step("sweep_rd", 1'b1);
        end

        for (int n = 0; n < 600; n++) begin
            int wa, wb;
            wa = int'($urandom_range(31));
            wb = int'($urandom_range(7));
            set_a($urandom_range(31) == 0, $urandom_range(3) != 0, wa, {$urandom, $urandom},
                  ($urandom_range(2) == 0) ? wa : int'($urandom_range(31)),
                  ($urandom_range(2) == 0) ? wa : int'($urandom_range(31)));
            set_b($urandom_range(31) == 0, $urandom_range(3) != 0, wb, WB'($urandom),
                  ($urandom_range(2) == 0) ? wb : int'($urandom_range(7)),
                  int'($urandom_range(7)),
                  ($urandom_range(2) == 0) ? wb : int'($urandom_range(7)));
            step("random", 1'b1);
        end

        set_a(0, 0, 0, '0, 0, 0); set_b(0, 0, 0, '0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
